stage_skid_reg: RTL and testbench
=================================

STAGE_SKID_REG -- requirements
Module: stage_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width in bits (PC and instruction packed, PC in upper 32).
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port freeze, input, 1, hazard stall; holds all state while high.
REQ-006 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-007 SHALL have port in_valid, input, 1, upstream offers in_data.
REQ-008 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-009 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-010 SHALL have port out_valid, output, 1, out_data is valid.
REQ-011 SHALL have port out_data, output, DATA_W, head-entry payload, driven from a register.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-013 SHALL have port occupancy, output, 2, number of buffered entries (0..2).
REQ-014 SHALL have port stall_cnt, output, CNT_W, saturating count of back-pressure cycles.

Function
REQ-015 SHALL hold a two-entry in-order buffer: head register (drives out_data) and skid register.
REQ-016 SHALL implement states EMPTY (occupancy 0), ONE (1), FULL (2).
REQ-017 SHALL drive in_ready = !freeze && state != FULL, combinationally from state and freeze only (no dependency on out_ready).
REQ-018 SHALL drive out_valid = !freeze && state != EMPTY.
REQ-019 SHALL define accept = in_valid && in_ready and pop = out_valid && out_ready.
REQ-020 EMPTY: accept -> ONE, head <= in_data; otherwise stay.
REQ-021 ONE: accept && pop -> ONE, head <= in_data; accept only -> FULL, skid <= in_data; pop only -> EMPTY, head <= 0; neither -> stay.
REQ-022 FULL: pop -> ONE, head <= skid, skid <= 0; otherwise stay (accept impossible).
REQ-023 SHALL deliver entries in acceptance order with no loss or duplication; minimum latency one cycle (accept at edge N, out_valid high after edge N).
REQ-024 SHALL sustain one accept and one pop per cycle in state ONE (full throughput).
REQ-025 freeze high: no state, head, skid or occupancy change; in_ready and out_valid low; in_valid/out_ready ignored.
REQ-026 flush high: next state EMPTY, head and skid <= 0, regardless of freeze, in_valid, out_ready; a coincident in_valid is dropped (in_ready may be high, entry still discarded).
REQ-027 Priority: rst > flush > freeze > accept/pop.
REQ-028 stall_cnt SHALL increment by 1 each cycle out_valid && !out_ready, saturate at all-ones, clear only on rst (flush does not clear it).
REQ-029 out_data SHALL equal 0 whenever state is EMPTY.

Reset
REQ-030 rst high SHALL immediately force state EMPTY, head, skid, stall_cnt to 0; outputs: out_valid 0, out_data 0, occupancy 0, in_ready = !freeze.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries; first edge after release behaves as EMPTY.

Verification
REQ-032 Stream: out_ready=1, in_valid=1, in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later each, occupancy stays 1, stall_cnt 0.
REQ-033 Back-pressure: push 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready 0, out_data 0xA; raise out_ready -> 0xA then 0xB popped, occupancy 0, stall_cnt = cycles out_ready was low while valid.
REQ-034 Freeze: FULL with 0xA,0xB, freeze=1 for 3 cycles with in_valid=1, out_ready=1 -> no change, out_valid 0, in_ready 0; after release 0xA then 0xB.
REQ-035 Flush: FULL, flush=1 with freeze=1 and in_valid=1 (0xC) -> next cycle occupancy 0, out_data 0, 0xC never appears.
REQ-036 Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 0xF.
REQ-037 Async reset: assert rst between edges in FULL -> out_valid, occupancy, out_data 0 before next edge; stall_cnt 0.

Source files
------------

// File: rtl/stage_skid_reg_if.sv
// Handshake bundle for stage_skid_reg: upstream offer/accept and downstream valid/ready.
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface stage_skid_reg_if #(
    parameter int unsigned DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stage_skid_reg.sv
// Two-entry in-order skid buffer between pipeline stages, with freeze, flush and
// a saturating back-pressure counter.
module stage_skid_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    stage_skid_reg_if.slave    bus,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] skid;
    logic              accept;
    logic              pop;

    // in_ready deliberately ignores out_ready so the upstream path stays short.
    assign bus.in_ready  = !freeze && (state != FULL);
    assign bus.out_valid = !freeze && (state != EMPTY);
    assign bus.out_data  = head;
    assign occupancy     = state;
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            head      <= '0;
            skid      <= '0;
            stall_cnt <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;

            if (flush) begin
                state <= EMPTY;
                head  <= '0;
                skid  <= '0;
            end else if (!freeze) begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            state <= ONE;
                            head  <= bus.in_data;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            head <= bus.in_data;
                        end else if (accept) begin
                            state <= FULL;
                            skid  <= bus.in_data;
                        end else if (pop) begin
                            state <= EMPTY;
                            head  <= '0;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            state <= ONE;
                            head  <= skid;
                            skid  <= '0;
                        end
                    end
                    default: begin
                        state <= EMPTY;
                        head  <= '0;
                        skid  <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stage_skid_reg.sv
// Bench for stage_skid_reg: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_stage_skid_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic [1:0]  occ16, occ4;
    logic [15:0] stall16;
    logic [3:0]  stall4;

    int unsigned total = 0;
    int unsigned bad   = 0;

    stage_skid_reg_if #(.DATA_W(64)) bus  ();
    stage_skid_reg_if #(.DATA_W(64)) bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_data   = bus.in_data;
    assign bus4.out_ready = bus.out_ready;

    stage_skid_reg #(.DATA_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .bus(bus.slave), .occupancy(occ16), .stall_cnt(stall16)
    );

    stage_skid_reg #(.DATA_W(64), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .bus(bus4.slave), .occupancy(occ4), .stall_cnt(stall4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO of accepted entries, at most two deep.
    logic [63:0] q[$];
    int unsigned m_stall = 0;

    always @(negedge clk) begin
        logic        e_in_ready, e_out_valid;
        logic [63:0] e_out_data;
        int unsigned e_stall4;
        if (rst) begin
            q.delete();
            m_stall = 0;
        end
        e_in_ready  = !freeze && (q.size() < 2);
        e_out_valid = !freeze && (q.size() > 0);
        e_out_data  = (q.size() > 0) ? q[0] : 64'd0;
        e_stall4    = (m_stall > 15) ? 15 : m_stall;

        chk("in_ready",   bus.in_ready,   e_in_ready);
        chk("out_valid",  bus.out_valid,  e_out_valid);
        chk("out_data",   bus.out_data,   e_out_data);
        chk("occupancy",  occ16,          64'(q.size()));
        chk("stall_cnt",  stall16,        64'((m_stall > 65535) ? 65535 : m_stall));
        chk("in_ready4",  bus4.in_ready,  e_in_ready);
        chk("out_valid4", bus4.out_valid, e_out_valid);
        chk("out_data4",  bus4.out_data,  e_out_data);
        chk("occupancy4", occ4,           64'(q.size()));
        chk("stall_cnt4", stall4,         64'(e_stall4));

        if (!rst) begin
            if (e_out_valid && !bus.out_ready) m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (e_out_valid && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && e_in_ready) q.push_back(bus.in_data);
            end
        end
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) step();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_occ",       occ16,         2'd0);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_stall",     stall16,       16'd0);
        rst = 1'b0;
        step();

        // Streaming at full throughput.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus.in_data = 64'(k);
            step();
            chk("stream_data", bus.out_data, 64'(k));
            chk("stream_occ",  occ16,        2'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_empty", occ16,   2'd0);
        chk("stream_stall", stall16, 16'd0);

        // Back-pressure fills the skid register.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_data = 64'hA; step();
        bus.in_data   = 64'hB; step();
        bus.in_valid  = 1'b0; step();
        chk("bp_occ",      occ16,         2'd2);
        chk("bp_in_ready", bus.in_ready,  1'b0);
        chk("bp_data",     bus.out_data,  64'hA);
        bus.out_ready = 1'b1; step();
        chk("bp_data2",    bus.out_data,  64'hB);
        step();
        chk("bp_occ0",     occ16,         2'd0);
        chk("bp_stall",    stall16,       16'd2);

        // Freeze while full.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_data = 64'hA; step();
        bus.in_data   = 64'hB; step();
        freeze = 1'b1; bus.in_data = 64'hD; bus.out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("frz_occ",   occ16,         2'd2);
            chk("frz_valid", bus.out_valid, 1'b0);
            chk("frz_ready", bus.in_ready,  1'b0);
        end
        freeze = 1'b0; bus.in_valid = 1'b0;
        #1 chk("frz_head", bus.out_data, 64'hA);
        step();
        chk("frz_next", bus.out_data, 64'hB);
        step();

        // Flush beats freeze and drops the coincident input.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_data = 64'hA; step();
        bus.in_data   = 64'hB; step();
        flush = 1'b1; freeze = 1'b1; bus.in_data = 64'hC; step();
        chk("fl_occ",  occ16,        2'd0);
        chk("fl_data", bus.out_data, 64'd0);
        flush = 1'b0; freeze = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) step();

        // Saturation of the narrow counter.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_data = 64'h55; step();
        bus.in_valid  = 1'b0;
        repeat (20) step();
        chk("sat4", stall4, 4'hF);

        // Asynchronous reset between edges while full.
        bus.in_valid = 1'b1; bus.in_data = 64'h66; step();
        bus.in_valid = 1'b0;
        chk("ar_full", occ16, 2'd2);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", bus.out_valid, 1'b0);
        chk("ar_occ",   occ16,         2'd0);
        chk("ar_data",  bus.out_data,  64'd0);
        chk("ar_stall", stall16,       16'd0);
        step();
        rst = 1'b0;
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            freeze        = ($urandom_range(0, 9) == 0);
            flush         = ($urandom_range(0, 19) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            bus.in_valid  = $urandom_range(0, 1) != 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.in_data   = {$urandom, $urandom};
            step();
        end
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
